// File: rtl/sdram_burst_dma.sv
// Burst DMA between the on-chip dual-port buffer and the SDRAM controller.
// Moves xfer_len words in fixed BURST-beat requests, either buffer->SDRAM or SDRAM->buffer.
module sdram_burst_dma #(
    parameter int unsigned   DW    = 16,
    parameter int unsigned   SAW   = 25,
    parameter int unsigned   MAW   = 10,
    parameter int unsigned   BURST = 8,
    parameter logic [DW-1:0] PAD   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_start,
    input  logic            rd_start,
    input  logic            abort,
    input  logic [MAW:0]    xfer_len,
    input  logic [SAW-1:0]  sd_base_wr,
    input  logic [SAW-1:0]  sd_base_rd,
    input  logic            ready,
    output logic            wr_req,
    output logic            rd_req,
    input  logic            wr_valid,
    input  logic            rd_valid,
    output logic [SAW-1:0]  adr_sdram,
    output logic [DW-1:0]   data_to_sdram,
    input  logic [DW-1:0]   data_from_sdram,
    output logic [MAW-1:0]  mem_rd_addr,
    input  logic [DW-1:0]   mem_rd_data,
    output logic            mem_we,
    output logic [MAW-1:0]  mem_wr_addr,
    output logic [DW-1:0]   mem_wr_data,
    output logic            busy,
    output logic            done,
    output logic            aborted
);

    localparam int unsigned BW = $clog2(BURST);
    localparam int unsigned LW = MAW + 1;
    // idx runs up to len rounded up to a whole burst, which can exceed the buffer depth
    localparam int unsigned IW = ((MAW > BW) ? MAW : BW) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_REQ,
        S_DATA,
        S_NEXT,
        S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic             dir_wr_q, dir_wr_d;
    logic [SAW-1:0]   base_q, base_d;
    logic [LW-1:0]    len_q, len_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             wr_req_q, wr_req_d;
    logic             rd_req_q, rd_req_d;
    logic [SAW-1:0]   adr_q, adr_d;
    logic             mem_we_q, mem_we_d;
    logic [MAW-1:0]   mem_wr_addr_q, mem_wr_addr_d;
    logic [DW-1:0]    mem_wr_data_q, mem_wr_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic             beat_c;
    logic             in_range_c;

    // A beat only counts while a burst is in its data phase, in the job's direction
    assign beat_c     = (state_q == S_DATA) && (dir_wr_q ? wr_valid : rd_valid);
    assign in_range_c = idx_q < IW'(len_q);

    // Look one word ahead on a write beat so the next word is ready after the 1-cycle buffer latency
    assign mem_rd_addr   = (state_q == S_IDLE) ? '0
                         : MAW'(idx_q + IW'(beat_c && dir_wr_q));
    assign data_to_sdram = ((state_q == S_DATA) && dir_wr_q)
                         ? (in_range_c ? mem_rd_data : PAD) : '0;

    assign wr_req      = wr_req_q;
    assign rd_req      = rd_req_q;
    assign adr_sdram   = adr_q;
    assign mem_we      = mem_we_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        dir_wr_d      = dir_wr_q;
        base_d        = base_q;
        len_d         = len_q;
        idx_d         = idx_q;
        beat_d        = beat_q;
        wr_req_d      = wr_req_q;
        rd_req_d      = rd_req_q;
        adr_d         = adr_q;
        mem_we_d      = 1'b0;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        aborted_d     = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (wr_start || rd_start) begin
                    dir_wr_d  = wr_start;
                    base_d    = wr_start ? sd_base_wr : sd_base_rd;
                    len_d     = xfer_len;
                    idx_d     = '0;
                    beat_d    = '0;
                    busy_d    = 1'b1;
                    aborted_d = 1'b0;
                    state_d   = (xfer_len == '0) ? S_FIN : S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (ready) begin
                    adr_d    = base_q + SAW'(idx_q);
                    wr_req_d = dir_wr_q;
                    rd_req_d = !dir_wr_q;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (beat_c) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    idx_d    = idx_q + IW'(1);
                    beat_d   = beat_q + BW'(1);
                    if (!dir_wr_q) begin
                        mem_wr_data_d = data_from_sdram;
                        mem_wr_addr_d = MAW'(idx_q);
                        mem_we_d      = in_range_c;
                    end
                    // Every burst runs to full length; trailing beats are padded or discarded
                    if (beat_q == BW'(BURST - 1)) begin
                        beat_d  = '0;
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (!in_range_c || abort) begin
                    aborted_d = in_range_c;
                    state_d   = S_FIN;
                end else begin
                    state_d = S_WAIT_RDY;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            dir_wr_q      <= 1'b0;
            base_q        <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            beat_q        <= '0;
            wr_req_q      <= 1'b0;
            rd_req_q      <= 1'b0;
            adr_q         <= '0;
            mem_we_q      <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_wr_q      <= dir_wr_d;
            base_q        <= base_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            beat_q        <= beat_d;
            wr_req_q      <= wr_req_d;
            rd_req_q      <= rd_req_d;
            adr_q         <= adr_d;
            mem_we_q      <= mem_we_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
        end
    end

endmodule

// File: tb/tb_sdram_burst_dma.sv
// Bench for sdram_burst_dma: buffer and SDRAM-controller models with queued expectations
// for burst addresses, write beats and buffer writes.
`timescale 1ns/1ps
module tb_sdram_burst_dma;

    localparam int unsigned DW    = 16;
    localparam int unsigned SAW   = 25;
    localparam int unsigned MAW   = 10;
    localparam int unsigned BURST = 8;
    localparam logic [DW-1:0] PAD_V = 16'h0000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_start, rd_start, abort;
    logic [MAW:0]    xfer_len;
    logic [SAW-1:0]  sd_base_wr, sd_base_rd;
    logic            ready;
    logic            wr_req, rd_req;
    logic            wr_valid, rd_valid;
    logic [SAW-1:0]  adr_sdram;
    logic [DW-1:0]   data_to_sdram, data_from_sdram;
    logic [MAW-1:0]  mem_rd_addr;
    logic [DW-1:0]   mem_rd_data;
    logic            mem_we;
    logic [MAW-1:0]  mem_wr_addr;
    logic [DW-1:0]   mem_wr_data;
    logic            busy, done, aborted;

    logic [DW-1:0]   bufmem [0:(1<<MAW)-1];

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_data [$];
    logic [26:0] exp_adr  [$];
    logic [26:0] exp_mw   [$];

    int gap, cool, abort_burst, cur_len;
    int done_cnt, wr_req_cnt, rd_req_cnt, mw_cnt, job_beat, job_bursts;
    int gap_cnt, beats_left;
    bit stall, active, cur_wr, req_chk_drop;

    sdram_burst_dma dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_start        (wr_start),
        .rd_start        (rd_start),
        .abort           (abort),
        .xfer_len        (xfer_len),
        .sd_base_wr      (sd_base_wr),
        .sd_base_rd      (sd_base_rd),
        .ready           (ready),
        .wr_req          (wr_req),
        .rd_req          (rd_req),
        .wr_valid        (wr_valid),
        .rd_valid        (rd_valid),
        .adr_sdram       (adr_sdram),
        .data_to_sdram   (data_to_sdram),
        .data_from_sdram (data_from_sdram),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .mem_we          (mem_we),
        .mem_wr_addr     (mem_wr_addr),
        .mem_wr_data     (mem_wr_data),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted)
    );

    always #5 clk = ~clk;

    // Buffer read port, one cycle of latency
    always @(posedge clk) mem_rd_data <= bufmem[mem_rd_addr];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One cycle: monitor outputs, then play the SDRAM controller for this cycle
    task automatic tick();
        logic [16:0] ed;
        logic [26:0] ea;
        @(negedge clk);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        if (!rst_n) begin
            active       = 1'b0;
            req_chk_drop = 1'b0;
            cool         = 0;
            ready        = 1'b1;
        end else begin
            if (done) done_cnt++;
            if (mem_we) begin
                if (exp_mw.size() > 0) ea = exp_mw.pop_front();
                else ea = 27'h4000000;
                chk("mem_write", 64'({1'b0, mem_wr_addr, mem_wr_data}), 64'(ea));
                mw_cnt++;
            end
            if (req_chk_drop) begin
                chk("req_drop", 64'(wr_req | rd_req), 64'(0));
                req_chk_drop = 1'b0;
            end
            if (cool > 0) begin
                cool--;
                if (cool == 0) ready = 1'b1;
            end
            if (active) begin
                if (gap_cnt > 0) begin
                    gap_cnt--;
                end else begin
                    if (beats_left == BURST) begin
                        chk("req_held", 64'(cur_wr ? wr_req : rd_req), 64'(1));
                        req_chk_drop = 1'b1;
                        if (abort_burst != 0 && job_bursts == abort_burst) abort = 1'b1;
                    end
                    if (cur_wr) begin
                        wr_valid = 1'b1;
                        #1;
                        if (exp_data.size() > 0) ed = {1'b0, exp_data.pop_front()};
                        else ed = 17'h10000;
                        chk("wr_data", 64'({1'b0, data_to_sdram}), 64'(ed));
                    end else begin
                        rd_valid        = 1'b1;
                        data_from_sdram = 16'hA000 + 16'(job_beat);
                        if (job_beat < cur_len)
                            exp_mw.push_back({1'b0, MAW'(job_beat), data_from_sdram});
                    end
                    job_beat++;
                    beats_left--;
                    gap_cnt = gap;
                    if (beats_left == 0) begin
                        active = 1'b0;
                        if (stall) begin
                            ready = 1'b0;
                            cool  = 5;
                        end
                    end
                end
            end else if (wr_req || rd_req) begin
                active     = 1'b1;
                cur_wr     = wr_req;
                beats_left = BURST;
                gap_cnt    = gap;
                job_bursts++;
                if (wr_req) wr_req_cnt++;
                else rd_req_cnt++;
                if (exp_adr.size() > 0) ea = exp_adr.pop_front();
                else ea = '1;
                chk("req_adr", 64'({wr_req, rd_req, adr_sdram}), 64'(ea));
            end
        end
    endtask

    task automatic clear_job(input int gap_i, input bit stall_i, input int abort_i, input int len);
        exp_data.delete();
        exp_adr.delete();
        exp_mw.delete();
        gap = gap_i; stall = stall_i; abort_burst = abort_i; cur_len = len;
        done_cnt = 0; wr_req_cnt = 0; rd_req_cnt = 0; mw_cnt = 0;
        job_beat = 0; job_bursts = 0;
    endtask

    task automatic run_job(input bit is_wr, input bit both, input int len, input logic [SAW-1:0] base,
                           input int gap_i, input bit stall_i, input int abort_i, input bit poke);
        int nb;
        int cyc;
        logic [SAW-1:0] a;
        clear_job(gap_i, stall_i, abort_i, len);
        nb = (len + BURST - 1) / BURST;
        if (abort_i != 0 && abort_i < nb) nb = abort_i;
        for (int b = 0; b < nb; b++) begin
            a = base + SAW'(b * BURST);
            exp_adr.push_back({is_wr, !is_wr, a});
        end
        if (is_wr)
            for (int i = 0; i < nb * BURST; i++) exp_data.push_back((i < len) ? bufmem[i] : PAD_V);
        if (stall_i) begin
            ready = 1'b0;
            cool  = 5;
        end
        tick();
        xfer_len   = (MAW+1)'(len);
        sd_base_wr = is_wr ? base : 25'h1ABCDE;
        sd_base_rd = is_wr ? 25'h0777 : base;
        wr_start   = is_wr;
        rd_start   = !is_wr || both;
        tick();
        wr_start   = 1'b0;
        rd_start   = 1'b0;
        xfer_len   = 11'd3;
        sd_base_wr = 25'h1FFFFFF;
        sd_base_rd = 25'h0000010;
        cyc = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            tick();
            cyc++;
            wr_start = poke && (cyc == 4);
            rd_start = poke && (cyc == 4);
        end
        wr_start = 1'b0;
        rd_start = 1'b0;
        repeat (20) tick();
        chk("done_pulses", 64'(done_cnt), 64'(1));
        chk("wr_reqs", 64'(wr_req_cnt), 64'(is_wr ? nb : 0));
        chk("rd_reqs", 64'(rd_req_cnt), 64'(is_wr ? 0 : nb));
        chk("adr_left", 64'(exp_adr.size()), 64'(0));
        chk("data_left", 64'(exp_data.size()), 64'(0));
        chk("mw_count", 64'(mw_cnt), 64'(is_wr ? 0 : ((len < nb * BURST) ? len : nb * BURST)));
        chk("busy_end", 64'(busy), 64'(0));
        chk("aborted", 64'(aborted), 64'((abort_i != 0) && (abort_i * BURST < len)));
        chk("idle_rd_addr", 64'(mem_rd_addr), 64'(0));
        abort = 1'b0;
        ready = 1'b1;
        cool  = 0;
    endtask

    task automatic zero_len_job();
        clear_job(0, 1'b0, 0, 0);
        tick();
        xfer_len   = '0;
        sd_base_wr = 25'h0000A0;
        wr_start   = 1'b1;
        tick();
        wr_start   = 1'b0;
        chk("zl_busy", 64'(busy), 64'(1));
        chk("zl_done_early", 64'(done), 64'(0));
        tick();
        chk("zl_done", 64'(done), 64'(1));
        chk("zl_busy_clr", 64'(busy), 64'(0));
        repeat (6) tick();
        chk("zl_no_req", 64'(wr_req_cnt + rd_req_cnt), 64'(0));
    endtask

    task automatic reset_mid_burst();
        int cyc;
        clear_job(0, 1'b0, 0, 16);
        for (int i = 0; i < 16; i++) exp_data.push_back(bufmem[i]);
        exp_adr.push_back({1'b1, 1'b0, 25'h0000100});
        tick();
        xfer_len   = 11'd16;
        sd_base_wr = 25'h0000100;
        wr_start   = 1'b1;
        tick();
        wr_start   = 1'b0;
        cyc = 0;
        while (job_beat < 3 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("rst_precond_busy", 64'(busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctrl", 64'({wr_req, rd_req, busy, done, aborted, mem_we}), 64'(0));
        chk("rst_adr", 64'(adr_sdram), 64'(0));
        chk("rst_data", 64'({data_to_sdram, mem_wr_data}), 64'(0));
        chk("rst_addr", 64'({mem_rd_addr, mem_wr_addr}), 64'(0));
        tick();
        tick();
        #2 rst_n = 1'b1;
        clear_job(0, 1'b0, 0, 0);
        tick();
        chk("rst_idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        rst_n = 1'b1;
        wr_start = 1'b0; rd_start = 1'b0; abort = 1'b0;
        xfer_len = '0; sd_base_wr = '0; sd_base_rd = '0;
        ready = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; data_from_sdram = '0;
        gap = 0; cool = 0; abort_burst = 0; cur_len = 0; stall = 1'b0;
        active = 1'b0; cur_wr = 1'b0; req_chk_drop = 1'b0;
        gap_cnt = 0; beats_left = 0;
        clear_job(0, 1'b0, 0, 0);
        for (int i = 0; i < (1 << MAW); i++) bufmem[i] = 16'(i);
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_ctrl", 64'({wr_req, rd_req, busy, done, aborted, mem_we}), 64'(0));
        chk("reset_adr", 64'({adr_sdram, mem_rd_addr, mem_wr_addr}), 64'(0));
        #2 rst_n = 1'b1;
        tick();

        run_job(1'b1, 1'b0, 16, 25'h0000100, 0, 1'b0, 0, 1'b0);   // plain write, two bursts
        run_job(1'b0, 1'b0, 12, 25'h0002000, 0, 1'b0, 0, 1'b0);   // read with discarded tail
        run_job(1'b1, 1'b0, 16, 25'h0000100, 2, 1'b1, 0, 1'b0);   // ready stalls, gapped beats
        run_job(1'b1, 1'b0, 64, 25'h0000040, 0, 1'b0, 2, 1'b0);   // abort in burst 2
        run_job(1'b1, 1'b0, 20, 25'h1FFFFF8, 0, 1'b0, 0, 1'b0);   // padding and address wrap
        zero_len_job();
        run_job(1'b1, 1'b1, 8, 25'h0000500, 0, 1'b0, 0, 1'b0);    // both strobes: write wins
        run_job(1'b1, 1'b0, 16, 25'h0000600, 0, 1'b0, 0, 1'b1);   // strobes while busy
        reset_mid_burst();
        run_job(1'b1, 1'b0, 16, 25'h0000300, 0, 1'b0, 0, 1'b0);   // clean job after reset

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
